// File: rtl/pll_lock_ctrl.sv
// Acquisition/lock sequencer for the 8-bit digital PLL: drives gain, NCO clear, integrator hold and lock status.
// Optional unlock-event counter output enabled by defining PLL_LOCK_CTRL_STATS_EN.
module pll_lock_ctrl #(
    parameter int unsigned PHASE_W      = 8,
    parameter int unsigned LOCK_THRESH  = 4,
    parameter int unsigned PULL_COUNT   = 32,
    parameter int unsigned LOCK_COUNT   = 64,
    parameter int unsigned UNLOCK_COUNT = 8,
    parameter int unsigned ACQ_TIMEOUT  = 4096
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_err_valid,
    input  logic signed [PHASE_W-1:0] i_phase_err,
    output logic [1:0]                o_gain_sel,
    output logic                      o_nco_clear,
    output logic                      o_integ_hold,
    output logic                      o_locked,
    output logic                      o_lock_lost,
    output logic [2:0]                o_state
`ifdef PLL_LOCK_CTRL_STATS_EN
    ,
    output logic [7:0]                o_unlock_events
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACQUIRE = 3'd2,
        S_PULL    = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    localparam logic [15:0] PULL_C   = 16'(PULL_COUNT);
    localparam logic [15:0] LOCK_C   = 16'(LOCK_COUNT);
    localparam logic [15:0] UNLOCK_C = 16'(UNLOCK_COUNT);
    localparam logic [15:0] TMO_C    = 16'(ACQ_TIMEOUT);

    state_t             state_q, state_n;
    logic [15:0]        good_q, good_n, tmo_q, tmo_n, bad_q, bad_n;
    logic               lost_n;
    logic [PHASE_W-1:0] mag;
    logic               good, near;

    function automatic logic [15:0] inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Most-negative code has no positive twin; clamp it to the largest positive magnitude.
    always_comb begin
        if (!i_phase_err[PHASE_W-1])
            mag = i_phase_err;
        else if (i_phase_err == {1'b1, {(PHASE_W-1){1'b0}}})
            mag = {1'b0, {(PHASE_W-1){1'b1}}};
        else
            mag = -i_phase_err;
    end

    assign good = 32'(mag) <= LOCK_THRESH;
    assign near = 32'(mag) <= 2 * LOCK_THRESH;

    always_comb begin
        state_n = state_q;
        good_n  = good_q;
        tmo_n   = tmo_q;
        bad_n   = bad_q;
        lost_n  = 1'b0;
        if (!i_enable) begin
            state_n = S_IDLE;
            good_n  = '0;
            tmo_n   = '0;
            bad_n   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n = S_CLEAR;
                    good_n  = '0;
                    tmo_n   = '0;
                    bad_n   = '0;
                end
                S_CLEAR: begin
                    state_n = S_ACQUIRE;
                    good_n  = '0;
                    tmo_n   = '0;
                    bad_n   = '0;
                end
                S_ACQUIRE: if (i_err_valid) begin
                    good_n = good ? inc(good_q) : '0;
                    tmo_n  = inc(tmo_q);
                    if (good_n >= PULL_C) begin
                        state_n = S_PULL;
                        good_n  = '0;
                    end else if (tmo_n >= TMO_C) begin
                        state_n = S_CLEAR;
                    end
                end
                S_PULL: if (i_err_valid) begin
                    if (good) begin
                        good_n = inc(good_q);
                        if (good_n >= LOCK_C) begin
                            state_n = S_LOCKED;
                            good_n  = '0;
                            bad_n   = '0;
                        end
                    end else if (!near) begin
                        state_n = S_ACQUIRE;
                        good_n  = '0;
                        tmo_n   = '0;
                    end else begin
                        good_n = '0;
                    end
                end
                S_LOCKED: if (i_err_valid) begin
                    if (good) begin
                        bad_n = '0;
                    end else begin
                        bad_n = inc(bad_q);
                        // Re-acquire from the current phase: no NCO clear here.
                        if (bad_n >= UNLOCK_C) begin
                            state_n = S_ACQUIRE;
                            lost_n  = 1'b1;
                            good_n  = '0;
                            tmo_n   = '0;
                            bad_n   = '0;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Outputs are registered decodes of the next state so they align with it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            good_q       <= '0;
            tmo_q        <= '0;
            bad_q        <= '0;
            o_gain_sel   <= 2'd0;
            o_nco_clear  <= 1'b0;
            o_integ_hold <= 1'b1;
            o_locked     <= 1'b0;
            o_lock_lost  <= 1'b0;
            o_state      <= 3'd0;
        end else begin
            state_q      <= state_n;
            good_q       <= good_n;
            tmo_q        <= tmo_n;
            bad_q        <= bad_n;
            o_gain_sel   <= (state_n == S_PULL) ? 2'd1 : (state_n == S_LOCKED) ? 2'd2 : 2'd0;
            o_nco_clear  <= (state_n == S_CLEAR);
            o_integ_hold <= (state_n == S_IDLE) || (state_n == S_CLEAR);
            o_locked     <= (state_n == S_LOCKED);
            o_lock_lost  <= lost_n;
            o_state      <= state_n;
        end
    end

`ifdef PLL_LOCK_CTRL_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_unlock_events <= 8'd0;
        else if (lost_n && o_unlock_events != 8'hFF)
            o_unlock_events <= o_unlock_events + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboarded bench for pll_lock_ctrl: a phase-level reference model predicts every cycle's outputs.
module tb_pll_lock_ctrl;

    localparam int THR = 4, PULLN = 32, LOCKN = 64, UNLK = 8, TMO = 4096, MAXMAG = 127;
    localparam int P_IDLE = 0, P_CLR = 1, P_ACQ = 2, P_PULL = 3, P_LOCK = 4;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1, i_enable = 1'b0, i_err_valid = 1'b0;
    logic signed [7:0] i_phase_err = '0;
    logic [1:0]        o_gain_sel;
    logic              o_nco_clear, o_integ_hold, o_locked, o_lock_lost;
    logic [2:0]        o_state;
    logic [7:0]        dut_ev;

    pll_lock_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_err_valid(i_err_valid), .i_phase_err(i_phase_err),
        .o_gain_sel(o_gain_sel), .o_nco_clear(o_nco_clear), .o_integ_hold(o_integ_hold),
        .o_locked(o_locked), .o_lock_lost(o_lock_lost), .o_state(o_state)
`ifdef PLL_LOCK_CTRL_STATS_EN
        , .o_unlock_events(dut_ev)
`endif
    );
`ifndef PLL_LOCK_CTRL_STATS_EN
    assign dut_ev = 8'd0;
`endif

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] gain;
        logic       clr;
        logic       hold;
        logic       locked;
        logic       lost;
        logic [2:0] st;
        logic [7:0] ev;
    } obs_t;

    obs_t q[$];
    int   errors = 0, checks = 0, n_lost_seen = 0, n_lock_seen = 0, n_clr_seen = 0;

    // Reference model: phase plus run-length counts of good/bad/total samples.
    int ph = P_IDLE, run_good = 0, run_bad = 0, n_acq = 0, n_unlock = 0;

    task automatic model_step(input bit rst, input bit en, input bit vld, input int e);
        int    m;
        bit    lost;
        obs_t  x;
        m    = (e < 0) ? -e : e;
        if (m > MAXMAG) m = MAXMAG;
        lost = 1'b0;
        if (rst) begin
            ph = P_IDLE; run_good = 0; run_bad = 0; n_acq = 0; n_unlock = 0;
        end else if (!en) begin
            ph = P_IDLE; run_good = 0; run_bad = 0; n_acq = 0;
        end else if (ph == P_IDLE) begin
            ph = P_CLR;
        end else if (ph == P_CLR) begin
            ph = P_ACQ; run_good = 0; run_bad = 0; n_acq = 0;
        end else if (vld) begin
            if (ph == P_ACQ) begin
                run_good = (m <= THR) ? run_good + 1 : 0;
                n_acq++;
                if (run_good == PULLN) begin ph = P_PULL; run_good = 0; end
                else if (n_acq == TMO) ph = P_CLR;
            end else if (ph == P_PULL) begin
                if (m <= THR) begin
                    run_good++;
                    if (run_good == LOCKN) begin ph = P_LOCK; run_good = 0; run_bad = 0; end
                end else if (m > 2 * THR) begin
                    ph = P_ACQ; run_good = 0; n_acq = 0;
                end else run_good = 0;
            end else if (ph == P_LOCK) begin
                if (m <= THR) run_bad = 0;
                else begin
                    run_bad++;
                    if (run_bad == UNLK) begin
                        ph = P_ACQ; lost = 1'b1; run_good = 0; run_bad = 0; n_acq = 0;
                        if (n_unlock < 255) n_unlock++;
                    end
                end
            end
        end
        x.gain   = (ph == P_PULL) ? 2'd1 : (ph == P_LOCK) ? 2'd2 : 2'd0;
        x.clr    = (ph == P_CLR);
        x.hold   = (ph == P_IDLE) || (ph == P_CLR);
        x.locked = (ph == P_LOCK);
        x.lost   = lost;
        x.st     = 3'(ph);
`ifdef PLL_LOCK_CTRL_STATS_EN
        x.ev     = 8'(n_unlock);
`else
        x.ev     = 8'd0;
`endif
        q.push_back(x);
    endtask

    task automatic cyc(input bit rst, input bit en, input bit vld, input int e);
        @(negedge i_clk);
        i_reset = rst; i_enable = en; i_err_valid = vld; i_phase_err = 8'(e);
        model_step(rst, en, vld, e);
    endtask

    task automatic run(input int n, input int e);
        repeat (n) cyc(1'b0, 1'b1, 1'b1, e);
    endtask

    // Monitor: the DUT presents a registered output every cycle; compare one expectation per edge.
    always @(posedge i_clk) begin
        obs_t ex, ac;
        #1;
        if (q.size() > 0) begin
            ex = q.pop_front();
            ac = '{o_gain_sel, o_nco_clear, o_integ_hold, o_locked, o_lock_lost, o_state, dut_ev};
            checks++;
            if (ac !== ex) begin
                errors++;
                $display("FAIL outputs t=%0t got gain=%0d clr=%0b hold=%0b lock=%0b lost=%0b st=%0d ev=%0d want gain=%0d clr=%0b hold=%0b lock=%0b lost=%0b st=%0d ev=%0d",
                         $time, ac.gain, ac.clr, ac.hold, ac.locked, ac.lost, ac.st, ac.ev,
                         ex.gain, ex.clr, ex.hold, ex.locked, ex.lost, ex.st, ex.ev);
            end
            if (o_lock_lost) n_lost_seen++;
            if (o_locked) n_lock_seen++;
            if (o_nco_clear) n_clr_seen++;
        end
    end

    initial begin
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 0);
        // Clean acquisition straight to lock.
        run(2 + PULLN + LOCKN + 4, 0);
        // Loss of lock: 7 bad, a good resets the run, then 8 saturating-magnitude bad.
        run(7, 20); run(1, 0); run(8, -128);
        // Acquisition run broken by a single bad sample.
        run(31, 3); run(1, 5); run(32, 0);
        // Pull-in: a marginal error resets the run, a large one falls back.
        run(10, 0); run(1, 6); run(5, 0); run(1, -9);
        // Timeout restart.
        run(TMO + 10, 100);
        // Enable drop while locked, then reset while locked.
        run(2 + PULLN + LOCKN + 2, 0);
        cyc(1'b0, 1'b0, 1'b1, 0); cyc(1'b0, 1'b0, 1'b1, 0);
        run(2 + PULLN + LOCKN + 2, 0);
        cyc(1'b1, 1'b1, 1'b1, 0); cyc(1'b0, 1'b1, 1'b1, 0);
        // Randomised segments: clean, marginal, or wild errors with sparse valid and rare enable/reset drops.
        for (int s = 0; s < 60; s++) begin
            int len, mode;
            len  = int'($urandom_range(40, 400));
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < len; k++) begin
                int e;
                bit vld, en, rst;
                vld = ($urandom_range(0, 9) < 8);
                en  = ($urandom_range(0, 499) != 0);
                rst = ($urandom_range(0, 999) == 0);
                case (mode)
                    0:       e = int'($urandom_range(0, 8)) - 4;
                    1:       e = int'($urandom_range(0, 18)) - 9;
                    default: e = int'($urandom_range(0, 255)) - 128;
                endcase
                cyc(rst, en, vld, e);
            end
        end
        repeat (3) @(posedge i_clk);
        #2;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL drain got=%0d want=0", q.size()); end
        checks++;
        if (n_lost_seen == 0) begin errors++; $display("FAIL lost_pulses got=0 want>0"); end
        checks++;
        if (n_lock_seen == 0) begin errors++; $display("FAIL locked_cycles got=0 want>0"); end
        checks++;
        if (n_clr_seen < 2) begin errors++; $display("FAIL clear_pulses got=%0d want>=2", n_clr_seen); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Acquisition and lock sequencer for the 8-bit digital PLL datapath. It watches the PLL's per-sample phase error and steps the loop through clear, acquire, pull-in and locked phases. In each phase it drives the loop-filter gain select, the NCO/integrator clear and hold controls, and a lock indication. It sits beside the PLL in the DSP chain and is the only block that configures the loop bandwidth.

## Interface
- PHASE_W, 8, width of signed phase-error input
- LOCK_THRESH, 4, |error| at or below this is a "good" sample
- PULL_COUNT, 32, consecutive good samples to leave ACQUIRE
- LOCK_COUNT, 64, consecutive good samples in PULL to declare lock
- UNLOCK_COUNT, 8, consecutive bad samples in LOCKED to declare loss
- ACQ_TIMEOUT, 4096, valid samples allowed in ACQUIRE before restart; counters are 16 bits
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  run request; low forces IDLE
- i_err_valid  in  1  qualifies i_phase_err, one sample per high cycle
- i_phase_err  in  PHASE_W  signed phase error from PLL detector
- o_gain_sel  out  2  loop-filter gain: 0 wide, 1 medium, 2 narrow
- o_nco_clear  out  1  one-cycle pulse clearing PLL NCO and integrator
- o_integ_hold  out  1  freezes PLL integrator
- o_locked  out  1  high only in LOCKED
- o_lock_lost  out  1  one-cycle pulse on LOCKED→ACQUIRE
- o_state  out  3  current state encoding

## Operation
- States: IDLE=0, CLEAR=1, ACQUIRE=2, PULL=3, LOCKED=4.
- Magnitude: |e| = -e for negative e. The most-negative code saturates to 2^(PHASE_W-1)-1. Only samples with i_err_valid=1 are evaluated.
- Good sample: |e| ≤ LOCK_THRESH. Bad sample: any other valid sample.
- IDLE:
  - Outputs: o_gain_sel=0, o_integ_hold=1, all counters cleared.
  - i_enable=1 → CLEAR.
- CLEAR: lasts one cycle, o_nco_clear=1, then → ACQUIRE. The timeout counter and good counter clear.
- ACQUIRE:
  - Outputs: o_gain_sel=0, o_integ_hold=0.
  - A good sample increments good_cnt; a bad sample zeroes it.
  - Every valid sample increments tmo_cnt.
  - good_cnt reaching PULL_COUNT → PULL, with good_cnt=0.
  - Otherwise, tmo_cnt reaching ACQ_TIMEOUT → CLEAR (full restart).
  - If both conditions hit on the same sample, PULL wins.
- PULL:
  - o_gain_sel=1.
  - Good sample → good_cnt+1; good_cnt reaching LOCK_COUNT → LOCKED.
  - Sample with |e| > 2·LOCK_THRESH → ACQUIRE, with good_cnt and tmo_cnt cleared.
  - Bad sample with |e| ≤ 2·LOCK_THRESH → good_cnt=0, stay in PULL.
- LOCKED:
  - Outputs: o_gain_sel=2, o_locked=1.
  - Bad sample → bad_cnt+1; good sample → bad_cnt=0.
  - bad_cnt reaching UNLOCK_COUNT → ACQUIRE, with o_lock_lost pulsed and counters cleared.
  - No NCO clear on this transition; the loop re-acquires from its current phase.
- i_enable=0 in any state → IDLE on the next edge. This has priority over all other transitions.
- Counters saturate and never wrap.

## Timing
- All outputs are registered.
- Transitions and output changes take effect on the edge after the deciding sample is sampled.
- Reset values: state IDLE; o_gain_sel=0, o_nco_clear=0, o_integ_hold=1, o_locked=0, o_lock_lost=0, o_state=0; all counters 0.
- Reset asserted mid-operation returns to IDLE on that edge. Reset overrides i_enable.
- Minimum enable-to-ACQUIRE latency: 2 cycles (IDLE→CLEAR→ACQUIRE).
- Minimum enable-to-lock latency: 2 cycles + PULL_COUNT + LOCK_COUNT valid samples.
- o_nco_clear and o_lock_lost are each high for exactly one cycle per event.
- Cycles with i_err_valid=0 leave all counters unchanged.

## Configuration
- PLL_LOCK_CTRL_STATS_EN defined:
  - Adds output o_unlock_events [7:0]: a saturating count (max 255) of LOCKED→ACQUIRE transitions.
  - Cleared by i_reset only; not cleared by i_enable=0.
- Undefined: the port and its counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset then enable, feeding valid samples of error 0 every cycle → o_nco_clear pulse at cycle 1, PULL after 32 samples (o_gain_sel=1), then o_locked=1 with o_gain_sel=2 after a further 64 samples.
- In ACQUIRE, feed 31 samples of error 3, then one of error 5, then 32 samples of 0 → state stays 2 until the 32nd sample after the error-5 sample.
- In PULL, inject error −9 (> 8) → next state ACQUIRE, gain 0, no o_nco_clear. A single error of 6 instead leaves the block in PULL with good_cnt reset.
- In LOCKED, feed 7 samples of error 20, one of 0, then 8 of −128 → no loss after the first 7. After the 8th −128 sample: o_lock_lost pulses once, o_locked drops, state goes to 2; with STATS_EN, o_unlock_events=1.
- Constant error 100 for 4096 valid samples → CLEAR re-entered, with a second o_nco_clear pulse.
- Drop i_enable, or assert i_reset, while LOCKED → IDLE next edge, o_locked=0, o_integ_hold=1, o_gain_sel=0.
